xor_diff_acc: RTL



---
 rtl/xor_diff_acc_if.sv | 23 ++
 rtl/xor_diff_acc.sv | 126 ++++++++++++
 2 files changed

// File: rtl/xor_diff_acc_if.sv
// rtl/xor_diff_acc_if.sv - XOR-word input stream and frame-total output handshake bundle
interface xor_diff_acc_if #(
    parameter int N     = 4,
    parameter int SUM_W = 6
);
    logic             in_vld;
    logic             in_rdy;
    logic [N-1:0]     in_data;
    logic             out_vld;
    logic             out_rdy;
    logic [SUM_W-1:0] out_sum;
    logic             out_ovf;

    modport master (
        output in_vld, in_data, out_rdy,
        input  in_rdy, out_vld, out_sum, out_ovf
    );

    modport slave (
        input  in_vld, in_data, out_rdy,
        output in_rdy, out_vld, out_sum, out_ovf
    );
endinterface

// File: rtl/xor_diff_acc.sv
// rtl/xor_diff_acc.sv - per-frame saturating Hamming-distance accumulator (optional XOR_DIFF_THRESH_EN alarm)
module xor_diff_acc #(
    parameter int N         = 4,
    parameter int FRAME_LEN = 8,
    parameter int SUM_W     = 6
`ifdef XOR_DIFF_THRESH_EN
    ,
    parameter logic [SUM_W-1:0] THRESH = 2
`endif
) (
    input  logic clk,
    input  logic rstn,
    input  logic clr,
    output logic busy,
`ifdef XOR_DIFF_THRESH_EN
    output logic out_alarm,
`endif
    xor_diff_acc_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ACC, HOLD} state_t;

    localparam logic [SUM_W-1:0] SUM_MAX = {SUM_W{1'b1}};
    localparam logic [SUM_W:0]   TOT_MAX = {1'b0, SUM_MAX};
    localparam logic [7:0]       LAST    = 8'(FRAME_LEN - 1);

    state_t           state, state_nx;
    logic [7:0]       cnt, cnt_nx;
    logic [SUM_W-1:0] sum, sum_nx;
    logic             ovf, ovf_nx;
    logic             vld, vld_nx;
    logic [N-1:0]     data_m;
    logic [SUM_W:0]   pc, base, tot;
    logic             accept, sat;

    // Mask the word when not valid so undriven data can never reach the adder.
    assign data_m = bus.in_vld ? bus.in_data : '0;

    always_comb begin
        pc = '0;
        for (int i = 0; i < N; i++) begin
            pc = pc + (SUM_W+1)'(data_m[i]);
        end
    end

    assign bus.in_rdy = (state != HOLD);
    assign accept     = bus.in_vld & bus.in_rdy;
    assign base       = (state == IDLE) ? '0 : {1'b0, sum};
    assign tot        = base + pc;
    assign sat        = (tot > TOT_MAX);

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        sum_nx   = sum;
        ovf_nx   = ovf;
        case (state)
            IDLE: begin
                if (accept) begin
                    sum_nx   = sat ? SUM_MAX : tot[SUM_W-1:0];
                    ovf_nx   = sat;
                    cnt_nx   = 8'd1;
                    state_nx = (FRAME_LEN == 1) ? HOLD : ACC;
                end
            end
            ACC: begin
                if (accept) begin
                    sum_nx = sat ? SUM_MAX : tot[SUM_W-1:0];
                    ovf_nx = ovf | sat;
                    cnt_nx = cnt + 8'd1;
                    if (cnt == LAST) state_nx = HOLD;
                end
            end
            HOLD: begin
                if (bus.out_rdy) begin
                    state_nx = IDLE;
                    sum_nx   = '0;
                    cnt_nx   = '0;
                    ovf_nx   = 1'b0;
                end
            end
            default: state_nx = IDLE;
        endcase
        // Abort wins over any accept or handoff in the same cycle.
        if (clr) begin
            state_nx = IDLE;
            sum_nx   = '0;
            cnt_nx   = '0;
            ovf_nx   = 1'b0;
        end
        vld_nx = (state_nx == HOLD);
    end

`ifdef XOR_DIFF_THRESH_EN
    logic alarm, alarm_nx;

    // sum/ovf are frozen in HOLD, so re-evaluating each cycle keeps the alarm stable.
    assign alarm_nx  = vld_nx & (ovf_nx | (sum_nx > THRESH));
    assign out_alarm = alarm;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) alarm <= 1'b0;
        else       alarm <= alarm_nx;
    end
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
            cnt   <= '0;
            sum   <= '0;
            ovf   <= 1'b0;
            vld   <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            sum   <= sum_nx;
            ovf   <= ovf_nx;
            vld   <= vld_nx;
        end
    end

    assign bus.out_vld = vld;
    assign bus.out_sum = sum;
    assign bus.out_ovf = ovf;
    assign busy        = (state != IDLE);
endmodule
